// File: rtl/isa_types_pkg.sv
// Shared ISA-level widths, instruction-memory timing and the fetch buffer entry type.
package isa_types;
    localparam int XLEN             = 32;
    localparam int ILEN             = 32;
    localparam int mem_read_latency = 2;
    localparam int INSTR_BYTES      = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] bits;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, bits} entries; flush empties it and overrides push/pop.
module fetch_fifo
    import isa_types::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);
    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // The fetch credit scheme must never let a push land on a full buffer.
            assert (!(push && full));
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, fixed-latency read tracking,
// instruction buffering and redirect flush ahead of decode.
module instr_fetch_unit
    import isa_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [XLEN-1:0] mem_addr,
    input  logic [ILEN-1:0] mem_q,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_bits,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int LAST = mem_read_latency - 1;

    logic [XLEN-1:0]             fetch_pc;
    logic [mem_read_latency-1:0] slot_valid;
    logic [XLEN-1:0]             slot_pc [mem_read_latency];
    logic [CW-1:0]               fifo_count;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        issue;
    logic                        capture;
    logic                        pop;
    int                          inflight_count;
    fetch_entry_t                push_entry;
    fetch_entry_t                head;

    always_comb begin
        inflight_count = 0;
        for (int k = 0; k < mem_read_latency; k++) begin
            inflight_count += int'(slot_valid[k]);
        end
    end

    // Reads in flight already own a buffer slot, so counting them prevents overflow.
    assign issue   = !redirect_valid && !fifo_full
                     && ((int'(fifo_count) + inflight_count) < FIFO_DEPTH);
    assign capture = slot_valid[LAST] && !redirect_valid;
    assign pop     = instr_valid && instr_ready && !redirect_valid;

    assign push_entry = '{pc: slot_pc[LAST], bits: mem_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_PC;
            mem_addr   <= RESET_PC;
            slot_valid <= '0;
            for (int k = 0; k < mem_read_latency; k++) begin
                slot_pc[k] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            slot_valid <= '0;
        end else begin
            slot_valid[0] <= issue;
            if (issue) begin
                mem_addr   <= fetch_pc;
                fetch_pc   <= fetch_pc + XLEN'(INSTR_BYTES);
                slot_pc[0] <= fetch_pc;
            end
            for (int k = 1; k < mem_read_latency; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_pc[k]    <= slot_pc[k-1];
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (capture),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign instr_valid = !fifo_empty;
    assign instr_pc    = head.pc;
    assign instr_bits  = head.bits;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 2-cycle memory returning addr ^ 0xA5A5A5A5.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] MAGIC  = 32'hA5A5_A5A5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_q = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_bits;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_addr       (mem_addr),
        .mem_q          (mem_q),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_bits     (instr_bits),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clock = ~clock;

    // Registered-read memory: data for an address is usable at the second edge after it appears.
    always @(posedge clock) mem_q <= mem_addr ^ MAGIC;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic apply_stimulus(input logic ready, input logic redir, input logic [31:0] rpc);
        instr_ready    = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_entry(input string tag, input logic [31:0] pc);
        check_output({tag, " valid"}, 32'(instr_valid), 32'd1);
        check_output({tag, " pc"}, instr_pc, pc);
        check_output({tag, " bits"}, instr_bits, pc ^ MAGIC);
    endtask

    initial begin
        reset_n = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        #12;
        check_output("reset valid", 32'(instr_valid), 32'd0);
        check_output("reset mem_addr", mem_addr, RST_PC);
        check_output("reset pc", instr_pc, 32'h0);
        check_output("reset bits", instr_bits, 32'h0);

        // Streaming from reset with decode always ready.
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check_output("stream e1 valid", 32'(instr_valid), 32'd0);
        check_output("stream e1 mem_addr", mem_addr, RST_PC);
        tick();
        check_output("stream e2 valid", 32'(instr_valid), 32'd0);
        check_output("stream e2 mem_addr", mem_addr, RST_PC + 32'd4);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_entry($sformatf("stream k%0d", k), RST_PC + 32'(4 * k));
            check_output($sformatf("stream k%0d mem_addr", k), mem_addr, RST_PC + 32'(8 + 4 * k));
        end

        // Asynchronous reset between edges, then backpressure from reset.
        #2 reset_n = 1'b0;
        #1;
        check_output("async reset valid", 32'(instr_valid), 32'd0);
        check_output("async reset mem_addr", mem_addr, RST_PC);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick(10);
        check_entry("stall head", RST_PC);
        check_output("stall mem_addr", mem_addr, RST_PC + 32'h0C);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_entry($sformatf("drain k%0d", k), RST_PC + 32'(4 * k));
        end
        check_output("drain mem_addr", mem_addr, RST_PC + 32'h20);

        // Redirect with two entries buffered and two reads in flight.
        reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick(4);
        check_entry("pre-redirect head", RST_PC);
        check_output("pre-redirect mem_addr", mem_addr, RST_PC + 32'h0C);
        apply_stimulus(1'b1, 1'b1, 32'h0000_2002);
        tick();
        check_output("redir r0 valid", 32'(instr_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        tick();
        check_output("redir r1 valid", 32'(instr_valid), 32'd0);
        check_output("redir r1 mem_addr", mem_addr, 32'h0000_2000);
        tick();
        check_output("redir r2 valid", 32'(instr_valid), 32'd0);
        tick();
        check_entry("redir r3", 32'h0000_2000);
        tick();
        check_entry("redir r4", 32'h0000_2004);
        tick();
        check_entry("redir r5", 32'h0000_2008);

        // Redirect coinciding with a pop, immediately followed by a second redirect.
        apply_stimulus(1'b1, 1'b1, 32'h0000_2800);
        tick();
        check_output("double r0 valid", 32'(instr_valid), 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h0000_3000);
        tick();
        check_output("double r1 valid", 32'(instr_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        tick();
        check_output("double r2 valid", 32'(instr_valid), 32'd0);
        check_output("double r2 mem_addr", mem_addr, 32'h0000_3000);
        tick();
        check_output("double r3 valid", 32'(instr_valid), 32'd0);
        tick();
        check_entry("double r4", 32'h0000_3000);
        tick();
        check_entry("double r5", 32'h0000_3004);

        // PC wrap past the top of the address space.
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        apply_stimulus(1'b1, 1'b0, 32'h0);
        tick(2);
        tick();
        check_entry("wrap 0", 32'hFFFF_FFF8);
        tick();
        check_entry("wrap 1", 32'hFFFF_FFFC);
        tick();
        check_entry("wrap 2", 32'h0000_0000);
        tick();
        check_entry("wrap 3", 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
